// File: rtl/picosoc_mem_arb_pkg.sv
// Shared types and constants for the PicoSoC two-master SRAM arbiter/bridge.
package picosoc_mem_arb_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned MEM_ADDR_W = 22;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        MID_CPU = 1'b0,
        MID_LDR = 1'b1
    } mid_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/picosoc_rr_arb2.sv
// Combinational 2-way round-robin grant: on a tie the master not granted last wins.
module picosoc_rr_arb2
    import picosoc_mem_arb_pkg::*;
(
    input  logic cpu_valid,
    input  logic ldr_valid,
    input  mid_t last_grant,
    output logic gnt_valid_c,
    output mid_t gnt_id_c
);

    always_comb begin
        gnt_valid_c = cpu_valid | ldr_valid;
        gnt_id_c    = MID_CPU;
        if (cpu_valid && ldr_valid) begin
            if (last_grant == MID_CPU) begin
                gnt_id_c = MID_LDR;
            end
        end else if (ldr_valid) begin
            gnt_id_c = MID_LDR;
        end
    end

endmodule

// File: rtl/picosoc_mem_arb.sv
// Two-master round-robin arbiter bridging PicoRV32-native requests onto a
// registered byte-writable SRAM port, with out-of-range flagging.
module picosoc_mem_arb
    import picosoc_mem_arb_pkg::*;
#(
    parameter int unsigned WORDS = 512
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [STRB_W-1:0]     cpu_wstrb,
    output logic [DATA_W-1:0]     cpu_rdata,

    input  logic                  ldr_valid,
    output logic                  ldr_ready,
    input  logic [ADDR_W-1:0]     ldr_addr,
    input  logic [DATA_W-1:0]     ldr_wdata,
    input  logic [STRB_W-1:0]     ldr_wstrb,
    output logic [DATA_W-1:0]     ldr_rdata,

    output logic [STRB_W-1:0]     mem_wen,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  err
);

    state_t                  state_q, state_d;
    mid_t                    gnt_q, gnt_d;
    mid_t                    last_q, last_d;
    logic                    in_range_q, in_range_d;
    logic [STRB_W-1:0]       mem_wen_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_d;
    logic                    cpu_ready_d, ldr_ready_d, err_d;

    logic                    arb_valid_c;
    mid_t                    arb_id_c;
    mem_req_t                sel_req_c;
    logic [MEM_ADDR_W-1:0]   sel_idx_c;
    logic                    sel_in_range_c;
    logic                    unused_addr_lsb_c;

    picosoc_rr_arb2 u_rr_arb2 (
        .cpu_valid   (cpu_valid),
        .ldr_valid   (ldr_valid),
        .last_grant  (last_q),
        .gnt_valid_c (arb_valid_c),
        .gnt_id_c    (arb_id_c)
    );

    // Request mux and range check for the master about to be granted.
    always_comb begin
        if (arb_id_c == MID_LDR) begin
            sel_req_c = '{addr: ldr_addr, wdata: ldr_wdata, wstrb: ldr_wstrb};
        end else begin
            sel_req_c = '{addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
        end
        sel_idx_c      = sel_req_c.addr[MEM_ADDR_W+1:2];
        sel_in_range_c = (sel_req_c.addr[ADDR_W-1:MEM_ADDR_W+2] == '0) &&
                         ({1'b0, sel_idx_c} < (MEM_ADDR_W+1)'(WORDS));
    end

    // Byte offset is irrelevant for a word-addressed SRAM.
    assign unused_addr_lsb_c = ^sel_req_c.addr[1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            gnt_q      <= MID_CPU;
            last_q     <= MID_LDR;
            in_range_q <= 1'b0;
            mem_wen    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ready  <= 1'b0;
            ldr_ready  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            in_range_q <= in_range_d;
            mem_wen    <= mem_wen_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_ready  <= cpu_ready_d;
            ldr_ready  <= ldr_ready_d;
            err        <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        in_range_d  = in_range_q;
        mem_wen_d   = mem_wen;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        cpu_ready_d = 1'b0;
        ldr_ready_d = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid_c) begin
                    gnt_d       = arb_id_c;
                    in_range_d  = sel_in_range_c;
                    mem_addr_d  = sel_idx_c;
                    mem_wdata_d = sel_req_c.wdata;
                    mem_wen_d   = sel_in_range_c ? sel_req_c.wstrb : '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_wen_d   = '0;
                cpu_ready_d = (gnt_q == MID_CPU);
                ldr_ready_d = (gnt_q == MID_LDR);
                err_d       = !in_range_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM read data only becomes valid in RESP, so it is steered through
    // combinationally behind the registered ready.
    assign cpu_rdata = (cpu_ready && in_range_q) ? mem_rdata : '0;
    assign ldr_rdata = (ldr_ready && in_range_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_picosoc_mem_arb.sv
// Directed self-checking bench for picosoc_mem_arb with a behavioural SRAM.
module tb_picosoc_mem_arb;

    logic        clk;
    logic        resetn;
    logic        cpu_valid, cpu_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        ldr_valid, ldr_ready;
    logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic [3:0]  ldr_wstrb;
    logic [3:0]  mem_wen;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sram [0:511];

    picosoc_mem_arb #(.WORDS(512)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_rdata (cpu_rdata),
        .ldr_valid (ldr_valid),
        .ldr_ready (ldr_ready),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_wstrb (ldr_wstrb),
        .ldr_rdata (ldr_rdata),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered SRAM: byte writes and one-cycle read latency.
    always @(posedge clk) begin
        if (mem_addr < 22'd512) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wen[b]) sram[mem_addr[8:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            mem_rdata <= sram[mem_addr[8:0]];
        end else begin
            mem_rdata <= 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic is_ldr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (is_ldr) begin
            ldr_valid = 1'b1; ldr_addr = addr; ldr_wdata = wdata; ldr_wstrb = wstrb;
        end else begin
            cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
        end
    endtask

    // One isolated access: address phase at N+1, completion at N+2.
    task automatic do_access(input logic is_ldr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic [21:0] exp_idx, input logic [31:0] exp_rdata,
                             input logic exp_err, input string tag);
        drive(is_ldr, addr, wdata, wstrb);
        step();
        check({tag, ".wen"},  32'(mem_wen), exp_err ? 32'h0 : 32'(wstrb));
        check({tag, ".addr"}, 32'(mem_addr), 32'(exp_idx));
        step();
        check({tag, ".ready"}, 32'(is_ldr ? ldr_ready : cpu_ready), 32'h1);
        check({tag, ".other_ready"}, 32'(is_ldr ? cpu_ready : ldr_ready), 32'h0);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".other_rdata"}, is_ldr ? cpu_rdata : ldr_rdata, 32'h0);
        if (wstrb == 4'h0) check({tag, ".rdata"}, is_ldr ? ldr_rdata : cpu_rdata, exp_rdata);
        cpu_valid = 1'b0;
        ldr_valid = 1'b0;
        step();
        check({tag, ".ready_drop"}, 32'(cpu_ready | ldr_ready), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) sram[i] = 32'h0;
        resetn = 1'b0;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        ldr_valid = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_wstrb = '0;
        step();
        step();
        check("rst.mem_wen",   32'(mem_wen), 32'h0);
        check("rst.mem_addr",  32'(mem_addr), 32'h0);
        check("rst.mem_wdata", mem_wdata, 32'h0);
        check("rst.readys",    32'({cpu_ready, ldr_ready, err}), 32'h0);
        check("rst.rdata",     cpu_rdata | ldr_rdata, 32'h0);
        resetn = 1'b1;
        step();

        do_access(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 22'd4, 32'h0, 1'b0, "cpu_wr");
        do_access(1'b0, 32'h10, 32'h0, 4'h0, 22'd4, 32'hDEADBEEF, 1'b0, "cpu_rd");
        do_access(1'b0, 32'h10, 32'h0000AA00, 4'h2, 22'd4, 32'h0, 1'b0, "cpu_bw");
        do_access(1'b0, 32'h10, 32'h0, 4'h0, 22'd4, 32'hDEADAAEF, 1'b0, "cpu_rd2");
        do_access(1'b1, 32'h20, 32'h12345678, 4'hF, 22'd8, 32'h0, 1'b0, "ldr_wr");
        do_access(1'b0, 32'h0, 32'hCAFEF00D, 4'hF, 22'd0, 32'h0, 1'b0, "cpu_wr0");
        do_access(1'b1, 32'h20, 32'h0, 4'h0, 22'd8, 32'h12345678, 1'b0, "ldr_rd");
        do_access(1'b1, 32'h800, 32'h55555555, 4'hF, 22'd512, 32'h0, 1'b1, "ldr_oor_wr");
        do_access(1'b1, 32'h0100_0000, 32'h0, 4'h0, 22'd0, 32'h0, 1'b1, "ldr_oor_rd");
        do_access(1'b0, 32'h0, 32'h0, 4'h0, 22'd0, 32'hCAFEF00D, 1'b0, "cpu_rd0");

        // Both masters valid straight out of reset: CPU first, then strict alternation.
        resetn = 1'b0;
        drive(1'b0, 32'h10, 32'h0, 4'h0);
        drive(1'b1, 32'h20, 32'h0, 4'h0);
        step();
        resetn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("rr.cpu_ready.%0d", k), 32'(cpu_ready), 32'((k == 2) || (k == 8)));
            check($sformatf("rr.ldr_ready.%0d", k), 32'(ldr_ready), 32'((k == 5) || (k == 11)));
            check($sformatf("rr.cpu_rdata.%0d", k), cpu_rdata,
                  ((k == 2) || (k == 8)) ? 32'hDEADAAEF : 32'h0);
            check($sformatf("rr.ldr_rdata.%0d", k), ldr_rdata,
                  ((k == 5) || (k == 11)) ? 32'h12345678 : 32'h0);
            if (k == 1) check("rr.addr_cpu", 32'(mem_addr), 32'd4);
            if (k == 4) check("rr.addr_ldr", 32'(mem_addr), 32'd8);
        end
        cpu_valid = 1'b0;
        ldr_valid = 1'b0;
        step();
        step();

        // Reset asserted while a CPU read is in ACCESS.
        drive(1'b0, 32'h10, 32'hA5A5A5A5, 4'h0);
        step();
        check("mid.addr", 32'(mem_addr), 32'd4);
        check("mid.wdata", mem_wdata, 32'hA5A5A5A5);
        resetn = 1'b0;
        cpu_valid = 1'b0;
        step();
        check("mid.cpu_ready", 32'(cpu_ready), 32'h0);
        check("mid.err", 32'(err), 32'h0);
        check("mid.mem_addr", 32'(mem_addr), 32'h0);
        check("mid.mem_wdata", mem_wdata, 32'h0);
        check("mid.mem_wen", 32'(mem_wen), 32'h0);
        check("mid.rdata", cpu_rdata, 32'h0);
        resetn = 1'b1;
        step();
        check("mid.no_late_ready", 32'(cpu_ready | ldr_ready), 32'h0);
        do_access(1'b0, 32'h10, 32'h0, 4'h0, 22'd4, 32'hDEADAAEF, 1'b0, "post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
